// File: rtl/data_mem_responder.sv
// Multi-channel memory responder: per-channel read and write engines that
// answer valid/ready requests after a fixed latency, plus a backdoor load port.
module data_mem_responder #(
   parameter int unsigned ADDR_BITS     = 8,
   parameter int unsigned DATA_BITS     = 8,
   parameter int unsigned NUM_CHANNELS  = 4,
   parameter int unsigned READ_LATENCY  = 2,
   parameter int unsigned WRITE_LATENCY = 2,
   parameter int unsigned WRITE_ENABLE  = 1
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic [NUM_CHANNELS-1:0]                mem_read_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address,
   output logic [NUM_CHANNELS-1:0]                mem_read_ready,
   output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data,
   input  logic [NUM_CHANNELS-1:0]                mem_write_valid,
   input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address,
   input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data,
   output logic [NUM_CHANNELS-1:0]                mem_write_ready,
   input  logic                                   load_enable,
   input  logic [ADDR_BITS-1:0]                   load_address,
   input  logic [DATA_BITS-1:0]                   load_data
);

   localparam int unsigned Depth  = 1 << ADDR_BITS;
   localparam logic [3:0]  RdLoad = 4'(READ_LATENCY - 1);
   localparam logic [3:0]  WrLoad = 4'(WRITE_LATENCY - 1);
   localparam logic        WrOn   = (WRITE_ENABLE != 0);

   typedef enum logic [1:0] {StIdle, StWait, StResp, StHold} state_e;

   logic [DATA_BITS-1:0] mem_q [Depth];

   state_e     rd_state_q [NUM_CHANNELS];
   state_e     rd_state_d [NUM_CHANNELS];
   logic [3:0] rd_cnt_q   [NUM_CHANNELS];
   logic [3:0] rd_cnt_d   [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] rd_addr_q, rd_addr_d;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] rd_data_q;
   logic [NUM_CHANNELS-1:0]                rd_fire;

   state_e     wr_state_q [NUM_CHANNELS];
   state_e     wr_state_d [NUM_CHANNELS];
   logic [3:0] wr_cnt_q   [NUM_CHANNELS];
   logic [3:0] wr_cnt_d   [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
   logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] wr_data_q, wr_data_d;
   logic [NUM_CHANNELS-1:0]                wr_fire;
   logic [NUM_CHANNELS-1:0]                wr_valid;

   // With writes disabled the write engines never see a request.
   assign wr_valid = WrOn ? mem_write_valid : '0;

   // Read engine next-state: accept, count down, respond once, wait for valid low.
   always_comb begin
      rd_addr_d = rd_addr_q;
      rd_fire   = '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         rd_state_d[c] = rd_state_q[c];
         rd_cnt_d[c]   = rd_cnt_q[c];
         case (rd_state_q[c])
            StIdle: if (mem_read_valid[c]) begin
               rd_addr_d[c]  = mem_read_address[c];
               rd_cnt_d[c]   = RdLoad;
               rd_state_d[c] = StWait;
            end
            StWait: if (rd_cnt_q[c] == 4'd0) begin
               rd_state_d[c] = StResp;
               rd_fire[c]    = 1'b1;
            end else begin
               rd_cnt_d[c] = rd_cnt_q[c] - 4'd1;
            end
            StResp: rd_state_d[c] = StHold;
            StHold: if (!mem_read_valid[c]) rd_state_d[c] = StIdle;
            default: rd_state_d[c] = StIdle;
         endcase
      end
   end

   // Write engine next-state: same sequencing; commit happens on the fire edge.
   always_comb begin
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_fire   = '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         wr_state_d[c] = wr_state_q[c];
         wr_cnt_d[c]   = wr_cnt_q[c];
         case (wr_state_q[c])
            StIdle: if (wr_valid[c]) begin
               wr_addr_d[c]  = mem_write_address[c];
               wr_data_d[c]  = mem_write_data[c];
               wr_cnt_d[c]   = WrLoad;
               wr_state_d[c] = StWait;
            end
            StWait: if (wr_cnt_q[c] == 4'd0) begin
               wr_state_d[c] = StResp;
               wr_fire[c]    = 1'b1;
            end else begin
               wr_cnt_d[c] = wr_cnt_q[c] - 4'd1;
            end
            StResp: wr_state_d[c] = StHold;
            StHold: if (!wr_valid[c]) wr_state_d[c] = StIdle;
            default: wr_state_d[c] = StIdle;
         endcase
      end
   end

   // Engine state registers; read data is sampled from storage before any same-edge write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_addr_q <= '0;
         rd_data_q <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            rd_state_q[c] <= StIdle;
            rd_cnt_q[c]   <= 4'd0;
            wr_state_q[c] <= StIdle;
            wr_cnt_q[c]   <= 4'd0;
         end
      end else begin
         rd_addr_q <= rd_addr_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            rd_state_q[c] <= rd_state_d[c];
            rd_cnt_q[c]   <= rd_cnt_d[c];
            wr_state_q[c] <= wr_state_d[c];
            wr_cnt_q[c]   <= wr_cnt_d[c];
            if (rd_fire[c]) rd_data_q[c] <= mem_q[rd_addr_q[c]];
         end
      end
   end

   // Storage is never cleared; later assignments win, so load < ch0 < ... < chN-1.
   always_ff @(posedge clk) begin
      if (load_enable) mem_q[load_address] <= load_data;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if (wr_fire[c] && !reset) mem_q[wr_addr_q[c]] <= wr_data_q[c];
      end
   end

   // Ready strobes decode the one-cycle response state.
   always_comb begin
      mem_read_data = rd_data_q;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         mem_read_ready[c]  = (rd_state_q[c] == StResp);
         mem_write_ready[c] = WrOn && (wr_state_q[c] == StResp);
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a data-memory instance checked every cycle
// against a timestamp-based behavioural model, plus a write-disabled program-memory instance.
module tb_data_mem_responder;

   localparam int RL = 2;
   localparam int WL = 2;

   logic clk;
   logic reset;

   logic [3:0]       rvalid, wvalid, rrdy, wrdy;
   logic [3:0][7:0]  raddr, waddr, wdata, rdata;
   logic             ld_en;
   logic [7:0]       ld_addr, ld_data;

   logic [3:0]       p_rvalid, p_wvalid, p_rrdy, p_wrdy;
   logic [3:0][7:0]  p_raddr, p_waddr;
   logic [3:0][15:0] p_wdata, p_rdata;
   logic             p_ld_en;
   logic [7:0]       p_ld_addr;
   logic [15:0]      p_ld_data;

   data_mem_responder #(
      .ADDR_BITS(8), .DATA_BITS(8), .NUM_CHANNELS(4),
      .READ_LATENCY(RL), .WRITE_LATENCY(WL), .WRITE_ENABLE(1)
   ) dut (
      .clk(clk), .reset(reset),
      .mem_read_valid(rvalid), .mem_read_address(raddr),
      .mem_read_ready(rrdy), .mem_read_data(rdata),
      .mem_write_valid(wvalid), .mem_write_address(waddr),
      .mem_write_data(wdata), .mem_write_ready(wrdy),
      .load_enable(ld_en), .load_address(ld_addr), .load_data(ld_data)
   );

   data_mem_responder #(
      .ADDR_BITS(8), .DATA_BITS(16), .NUM_CHANNELS(4),
      .READ_LATENCY(RL), .WRITE_LATENCY(WL), .WRITE_ENABLE(0)
   ) pdut (
      .clk(clk), .reset(reset),
      .mem_read_valid(p_rvalid), .mem_read_address(p_raddr),
      .mem_read_ready(p_rrdy), .mem_read_data(p_rdata),
      .mem_write_valid(p_wvalid), .mem_write_address(p_waddr),
      .mem_write_data(p_wdata), .mem_write_ready(p_wrdy),
      .load_enable(p_ld_en), .load_address(p_ld_addr), .load_data(p_ld_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input int ch, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s ch%0d: got %0h want %0h (t=%0t)", name, ch, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each request is a timestamp: accepted at edge A, answered at edge A+LAT,
   // channel free again once valid is seen low two or more edges after the answer.
   int          cyc = 0;
   logic [7:0]  mem_m [256];
   bit          rbusy [4], rserved [4], wbusy [4], wserved [4], commit [4];
   int          rdone [4], wdone [4];
   logic [7:0]  ra [4], wa [4], wd [4];
   logic [3:0]  exp_rrdy = '0, exp_wrdy = '0;
   logic [7:0]  exp_rdata [4];

   initial for (int c = 0; c < 4; c++) exp_rdata[c] = 8'h00;

   always @(posedge clk) begin
      cyc++;
      exp_rrdy = '0;
      exp_wrdy = '0;
      for (int c = 0; c < 4; c++) commit[c] = 1'b0;
      if (reset) begin
         for (int c = 0; c < 4; c++) begin
            rbusy[c] = 1'b0; wbusy[c] = 1'b0; exp_rdata[c] = 8'h00;
         end
      end else begin
         for (int c = 0; c < 4; c++) begin
            if (rbusy[c]) begin
               if (!rserved[c] && cyc == rdone[c]) begin
                  exp_rrdy[c] = 1'b1; exp_rdata[c] = mem_m[ra[c]]; rserved[c] = 1'b1;
               end else if (rserved[c] && cyc >= rdone[c] + 2 && !rvalid[c]) begin
                  rbusy[c] = 1'b0;
               end
            end else if (rvalid[c]) begin
               rbusy[c] = 1'b1; rserved[c] = 1'b0; ra[c] = raddr[c]; rdone[c] = cyc + RL;
            end
            if (wbusy[c]) begin
               if (!wserved[c] && cyc == wdone[c]) begin
                  exp_wrdy[c] = 1'b1; commit[c] = 1'b1; wserved[c] = 1'b1;
               end else if (wserved[c] && cyc >= wdone[c] + 2 && !wvalid[c]) begin
                  wbusy[c] = 1'b0;
               end
            end else if (wvalid[c]) begin
               wbusy[c] = 1'b1; wserved[c] = 1'b0; wa[c] = waddr[c]; wd[c] = wdata[c];
               wdone[c] = cyc + WL;
            end
         end
      end
      if (ld_en) mem_m[ld_addr] = ld_data;
      for (int c = 0; c < 4; c++) if (commit[c]) mem_m[wa[c]] = wd[c];
   end

   // ---------------- compare process + pulse monitor ----------------
   int          rp_cnt [4], rp_cyc [4], wp_cnt [4], wp_cyc [4];
   logic [7:0]  rp_data [4];
   int          pr_cnt, pw_cnt;
   logic [15:0] pr_data;

   always @(posedge clk) begin
      #1;
      check("rd_ready", 0, 32'(rrdy), 32'(exp_rrdy));
      check("wr_ready", 0, 32'(wrdy), 32'(exp_wrdy));
      for (int c = 0; c < 4; c++) check("rd_data", c, 32'(rdata[c]), 32'(exp_rdata[c]));
      check("pmem_wr_ready", 0, 32'(p_wrdy), 32'h0);
      for (int c = 0; c < 4; c++) begin
         if (rrdy[c]) begin rp_cnt[c]++; rp_cyc[c] = cyc; rp_data[c] = rdata[c]; end
         if (wrdy[c]) begin wp_cnt[c]++; wp_cyc[c] = cyc; end
      end
      if (p_rrdy[0]) begin pr_cnt++; pr_data = p_rdata[0]; end
      if (p_wrdy != 4'h0) pw_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clr_mon();
      for (int c = 0; c < 4; c++) begin rp_cnt[c] = 0; wp_cnt[c] = 0; end
      pr_cnt = 0; pw_cnt = 0;
   endtask

   task automatic do_read(input int ch, input logic [7:0] a, input logic [7:0] exp,
                          input string name);
      int n;
      rvalid[ch] = 1'b1; raddr[ch] = a; n = cyc + 1; clr_mon();
      tick(4);
      check({name, "_cnt"}, ch, 32'(rp_cnt[ch]), 32'd1);
      check({name, "_lat"}, ch, 32'(rp_cyc[ch] - n), 32'd2);
      check({name, "_data"}, ch, 32'(rp_data[ch]), 32'(exp));
      rvalid[ch] = 1'b0;
      tick(2);
   endtask

   task automatic do_write(input int ch, input logic [7:0] a, input logic [7:0] d,
                           input string name);
      int n;
      wvalid[ch] = 1'b1; waddr[ch] = a; wdata[ch] = d; n = cyc + 1; clr_mon();
      tick(4);
      check({name, "_cnt"}, ch, 32'(wp_cnt[ch]), 32'd1);
      check({name, "_lat"}, ch, 32'(wp_cyc[ch] - n), 32'd2);
      wvalid[ch] = 1'b0;
      tick(2);
   endtask

   initial begin
      int n;
      reset = 1'b1;
      rvalid = '0; wvalid = '0; raddr = '0; waddr = '0; wdata = '0;
      ld_en = 1'b0; ld_addr = '0; ld_data = '0;
      p_rvalid = '0; p_wvalid = '0; p_raddr = '0; p_waddr = '0; p_wdata = '0;
      p_ld_en = 1'b0; p_ld_addr = '0; p_ld_data = '0;
      clr_mon();
      tick(3);
      check("reset_rd_data", 0, 32'(rdata), 32'h0);
      check("reset_ready", 0, 32'({rrdy, wrdy}), 32'h0);
      reset = 1'b0;

      // Preload every word so no read ever sees uninitialised storage.
      for (int a = 0; a < 256; a++) begin
         ld_en = 1'b1; ld_addr = 8'(a);
         ld_data = (a < 4) ? 8'(a + 1) : (a == 'h10) ? 8'h5A : (a == 'h40) ? 8'h01 : 8'h00;
         p_ld_en = (a == 5); p_ld_addr = 8'(a); p_ld_data = 16'hBEEF;
         tick(1);
      end
      ld_en = 1'b0; p_ld_en = 1'b0;
      tick(1);

      // Read with valid held: single ready at N+2, none again through N+4.
      rvalid[0] = 1'b1; raddr[0] = 8'h10; n = cyc + 1; clr_mon();
      tick(5);
      check("held_rd_cnt", 0, 32'(rp_cnt[0]), 32'd1);
      check("held_rd_lat", 0, 32'(rp_cyc[0] - n), 32'd2);
      check("held_rd_data", 0, 32'(rp_data[0]), 32'h5A);
      rvalid[0] = 1'b0;
      tick(2);

      do_write(1, 8'h20, 8'hC3, "wr20");
      do_read(2, 8'h20, 8'hC3, "rd20");

      // All channels read together.
      n = cyc + 1; clr_mon();
      for (int c = 0; c < 4; c++) begin rvalid[c] = 1'b1; raddr[c] = 8'(c); end
      tick(4);
      for (int c = 0; c < 4; c++) begin
         check("all_rd_lat", c, 32'(rp_cyc[c] - n), 32'd2);
         check("all_rd_data", c, 32'(rp_data[c]), 32'(c + 1));
      end
      rvalid = '0;
      tick(2);

      // Same-edge write conflict with a load on the commit edge.
      wvalid[0] = 1'b1; waddr[0] = 8'h30; wdata[0] = 8'h11;
      wvalid[3] = 1'b1; waddr[3] = 8'h30; wdata[3] = 8'h99;
      clr_mon();
      tick(2);
      ld_en = 1'b1; ld_addr = 8'h30; ld_data = 8'h77;
      tick(1);
      ld_en = 1'b0;
      tick(1);
      check("conf_wr_cnt", 0, 32'(wp_cnt[0]), 32'd1);
      check("conf_wr_cnt", 3, 32'(wp_cnt[3]), 32'd1);
      wvalid = '0;
      tick(2);
      do_read(1, 8'h30, 8'h99, "rd30");

      // Read completing on a write-commit edge returns the old value.
      rvalid[0] = 1'b1; raddr[0] = 8'h40;
      wvalid[1] = 1'b1; waddr[1] = 8'h40; wdata[1] = 8'h02;
      clr_mon();
      tick(4);
      check("rw_same_edge", 0, 32'(rp_cyc[0]), 32'(wp_cyc[1]));
      check("rw_old_data", 0, 32'(rp_data[0]), 32'h01);
      rvalid = '0; wvalid = '0;
      tick(2);
      do_read(2, 8'h40, 8'h02, "rd40");

      // Reset during write WAIT discards it; a new request is taken right after release.
      wvalid[0] = 1'b1; waddr[0] = 8'h50; wdata[0] = 8'hEE; clr_mon();
      tick(1);
      reset = 1'b1; wvalid[0] = 1'b0;
      tick(1);
      reset = 1'b0;
      wvalid[0] = 1'b1; waddr[0] = 8'h51; wdata[0] = 8'h3C; n = cyc + 1;
      tick(4);
      check("rst_wr_cnt", 0, 32'(wp_cnt[0]), 32'd1);
      check("rst_new_lat", 0, 32'(wp_cyc[0] - n), 32'd2);
      wvalid[0] = 1'b0;
      tick(2);
      do_read(0, 8'h50, 8'h00, "rd50");
      do_read(0, 8'h51, 8'h3C, "rd51");

      // Program-memory instance ignores writes.
      p_wvalid[0] = 1'b1; p_waddr[0] = 8'h05; p_wdata[0] = 16'h1234; clr_mon();
      tick(10);
      p_wvalid[0] = 1'b0;
      check("pmem_wr_pulses", 0, 32'(pw_cnt), 32'd0);
      p_rvalid[0] = 1'b1; p_raddr[0] = 8'h05;
      tick(4);
      check("pmem_rd_cnt", 0, 32'(pr_cnt), 32'd1);
      check("pmem_rd_data", 0, 32'(pr_data), 32'hBEEF);
      p_rvalid[0] = 1'b0;
      tick(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Cycle-accurate model of the external multi-channel async memory that answers the GPU's program- and data-memory controller requests.
- Storage is 2^ADDR_BITS words of DATA_BITS each.
- Each channel has independent read and write engines that complete a valid/ready handshake after a programmable latency.
- The testbench instantiates it once for data memory (writes on) and once for program memory (WRITE_ENABLE=0), preloaded through a backdoor load port.

Parameters:
- ADDR_BITS, 8, address width; depth = 2^ADDR_BITS.
- DATA_BITS, 8, word width (16 for program memory).
- NUM_CHANNELS, 4, concurrent request channels.
- READ_LATENCY, 2, cycles from read acceptance to read_ready; legal range 1..15.
- WRITE_LATENCY, 2, cycles from write acceptance to write_ready; legal range 1..15.
- WRITE_ENABLE, 1, 0 removes the write engines; write_ready is tied 0.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high.
- mem_read_valid  input  [NUM_CHANNELS]  per-channel read request.
- mem_read_address  input  [ADDR_BITS] x NUM_CHANNELS  read address; must be held while valid is high.
- mem_read_ready  output  [NUM_CHANNELS]  one-cycle read completion strobe.
- mem_read_data  output  [DATA_BITS] x NUM_CHANNELS  read result.
- mem_write_valid  input  [NUM_CHANNELS]  per-channel write request.
- mem_write_address  input  [ADDR_BITS] x NUM_CHANNELS  write address.
- mem_write_data  input  [DATA_BITS] x NUM_CHANNELS  write data.
- mem_write_ready  output  [NUM_CHANNELS]  one-cycle write completion strobe.
- load_enable  input  1  backdoor write strobe.
- load_address  input  [ADDR_BITS]  backdoor address.
- load_data  input  [DATA_BITS]  backdoor data.

Behaviour:
- Reset (asynchronous, active-high):
  - All engines go to IDLE.
  - mem_read_ready=0, mem_write_ready=0, mem_read_data=0, latency counters=0.
  - Storage contents are NOT cleared.
  - Reset mid-operation abandons in-flight requests: no ready is issued and a pending write is discarded.
- Each engine, per channel and per direction, has states IDLE, WAIT, RESP, HOLD.
- IDLE:
  - Stays in IDLE while valid is low.
  - Valid sampled high at edge N: capture the address (and data for writes), load counter = LATENCY-1, go to WAIT.
- WAIT:
  - Decrement the counter each edge.
  - When the counter is 0, go to RESP.
  - Ready rises at edge N+LATENCY. With LATENCY=1, ready rises at edge N+1.
- RESP:
  - Ready is high for exactly one cycle.
  - Read engine: on entry to RESP, mem_read_data is loaded from storage at the captured address. It holds that value until the next read completion on the same channel.
  - Write engine: storage is updated at the edge that enters RESP.
  - Next state is HOLD.
- HOLD:
  - Ready is 0.
  - Go to IDLE on the first edge where valid is sampled low.
  - This prevents a still-held valid from being served twice; a new request can therefore be accepted no earlier than one cycle after valid drops.
- Address or data changes while in WAIT, RESP or HOLD are ignored, because the values were captured at acceptance.
- Read and write engines on the same channel are independent and may run concurrently.
- Same-edge conflicts, in priority order:
  - Multiple channel writes to one address on the same edge: highest channel index wins.
  - Channel write beats load_enable to the same address.
  - Read completing on the same edge as a write commit to the same address returns the pre-write value.
- load_enable writes storage on any edge regardless of engine states, subject to the priority above.
- WRITE_ENABLE=0:
  - mem_write_valid is ignored.
  - mem_write_ready is constantly 0.
  - Storage changes only through the load port.
- Address arithmetic: none; the full ADDR_BITS range maps 1:1 to storage, with no wrap logic needed.

Test Plan:
- Load addr 0x10=0x5A; ch0 read 0x10 with valid held, READ_LATENCY=2 → read_ready[0] high only in cycle N+2, read_data[0]=0x5A. No second ready while valid stays high through cycle N+4.
- ch1 write 0x20←0xC3 (WRITE_LATENCY=2), then ch2 reads 0x20 after valid drops → write_ready[1] one-cycle pulse at N+2; read returns 0xC3.
- All 4 channels read 0x00..0x03 (preloaded 1..4) on the same edge → all ready pulses coincide at N+2, data 1,2,3,4.
- ch0 writes 0x30←0x11 and ch3 writes 0x30←0x99 on the same edge, with load 0x30←0x77 also on that edge → memory[0x30]=0x99.
- ch0 read of 0x40 (old 0x01) completes on the same edge as ch1 write commit 0x40←0x02 → read_data=0x01; a subsequent read returns 0x02.
- Assert reset during WAIT of a ch0 write 0x50←0xEE (old 0x00) → no write_ready; memory[0x50] stays 0x00; channel accepts a new request right after reset release.
- WRITE_ENABLE=0 instance: write_valid held 10 cycles → write_ready stays 0, memory unchanged.
